muldiv_unit: RTL

Iterative RV32M multiply/divide functional unit sitting directly downstream of the reservation station. It accepts one issued instruction per `fu_start` pulse with fully resolved operands and computes the result over multiple cycles. It holds the result until the common data bus grants it, then returns to idle. The unit is single-occupancy: `fu_ready` is the back-pressure seen by the reservation station.

---
 rtl/muldiv_unit_if.sv | 30 +++
 rtl/muldiv_unit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - issue/result bus between reservation station, muldiv unit and CDB
interface muldiv_unit_if #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 3
);
   logic                  flush;
   logic                  fu_start;
   logic [DATA_WIDTH-1:0] fu_op1;
   logic [DATA_WIDTH-1:0] fu_op2;
   logic [DATA_WIDTH-1:0] fu_op3;
   logic [4:0]            fu_opcode;
   logic [TAG_WIDTH-1:0]  fu_dest_tag;
   logic [4:0]            fu_dest_reg;
   logic                  fu_ready;
   logic                  cdb_req;
   logic                  cdb_grant;
   logic [DATA_WIDTH-1:0] res_value;
   logic [TAG_WIDTH-1:0]  res_tag;
   logic [4:0]            res_dest_reg;

   modport master (
      output flush, fu_start, fu_op1, fu_op2, fu_op3, fu_opcode, fu_dest_tag, fu_dest_reg, cdb_grant,
      input  fu_ready, cdb_req, res_value, res_tag, res_dest_reg
   );

   modport slave (
      input  flush, fu_start, fu_op1, fu_op2, fu_op3, fu_opcode, fu_dest_tag, fu_dest_reg, cdb_grant,
      output fu_ready, cdb_req, res_value, res_tag, res_dest_reg
   );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit; MULDIV_FAST_MUL_EN selects single-cycle multiply
module muldiv_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 3
) (
   input  logic         clk,
   input  logic         rst,
   muldiv_unit_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

   state_t                r_state;
   logic [4:0]            r_cnt;
   logic                  r_fin;      // all 32 iterations done, next edge finalizes
   logic                  r_spec;     // result already resolved at issue, finalize keeps it
   logic [1:0]            r_sel;      // funct3[1:0] of the op in flight
   logic [65:0]           r_acc;
   logic [65:0]           r_mcand;
   logic [32:0]           r_mplier;
   logic [31:0]           r_rem;
   logic [31:0]           r_quo;
   logic [31:0]           r_dvsr;
   logic                  r_neg_q;
   logic                  r_neg_r;
   logic                  r_cdb_req;
   logic [DATA_WIDTH-1:0] r_res_value;
   logic [TAG_WIDTH-1:0]  r_res_tag;
   logic [4:0]            r_res_dest_reg;

   // Issue-time decode and operand preparation
   logic [2:0]  w_f3;
   logic        w_legal, w_is_div, w_is_rem, w_div_signed;
   logic        w_a_signed, w_b_signed;
   logic [32:0] w_a33, w_b33;
   logic [65:0] w_a66, w_acc_init;
   logic        w_op1_neg, w_op2_neg;
   logic [31:0] w_op1_mag, w_op2_mag;
   logic        w_div_zero, w_div_ovf;

   assign w_f3         = bus.fu_opcode[2:0];
   assign w_legal      = (bus.fu_opcode[4:3] == 2'b01);
   assign w_is_div     = w_f3[2];
   assign w_is_rem     = w_f3[1];
   assign w_div_signed = ~w_f3[0];
   assign w_a_signed   = ~(w_f3[1] & w_f3[0]);
   assign w_b_signed   = ~w_f3[1];
   assign w_a33        = {w_a_signed & bus.fu_op1[31], bus.fu_op1};
   assign w_b33        = {w_b_signed & bus.fu_op2[31], bus.fu_op2};
   assign w_a66        = {{33{w_a33[32]}}, w_a33};
   // A negative multiplier's sign bit weighs -2^32; pre-charge it so the loop only handles bits 0..31
   assign w_acc_init   = w_b33[32] ? (66'd0 - {w_a66[33:0], 32'd0}) : 66'd0;
   assign w_op1_neg    = w_div_signed & bus.fu_op1[31];
   assign w_op2_neg    = w_div_signed & bus.fu_op2[31];
   assign w_op1_mag    = w_op1_neg ? (32'd0 - bus.fu_op1) : bus.fu_op1;
   assign w_op2_mag    = w_op2_neg ? (32'd0 - bus.fu_op2) : bus.fu_op2;
   assign w_div_zero   = (bus.fu_op2 == 32'd0);
   assign w_div_ovf    = w_div_signed & (bus.fu_op1 == 32'h8000_0000) & (bus.fu_op2 == 32'hFFFF_FFFF);

   // Per-iteration datapath
   logic [65:0] w_acc_step;
   logic [32:0] w_rem_shift;
   logic [33:0] w_diff;
   logic        w_rem_ok;

   assign w_acc_step  = r_acc + (r_mplier[0] ? r_mcand : 66'd0);
   assign w_rem_shift = {r_rem, r_quo[31]};
   assign w_diff      = {1'b0, w_rem_shift} - {2'b00, r_dvsr};
   assign w_rem_ok    = ~w_diff[33];

   // Result formatting
   logic [31:0] w_mul_res, w_quo_fix, w_rem_fix, w_div_res;
   assign w_mul_res = (r_sel == 2'd0) ? r_acc[31:0] : r_acc[63:32];
   assign w_quo_fix = r_neg_q ? (32'd0 - r_quo) : r_quo;
   assign w_rem_fix = r_neg_r ? (32'd0 - r_rem) : r_rem;
   assign w_div_res = r_sel[1] ? w_rem_fix : w_quo_fix;

   logic w_unused;
`ifdef MULDIV_FAST_MUL_EN
   logic [65:0] w_fast_prod;
   logic [31:0] w_fast_res;
   assign w_fast_prod = $signed(w_a33) * $signed(w_b33);
   assign w_fast_res  = (w_f3[1:0] == 2'd0) ? w_fast_prod[31:0] : w_fast_prod[63:32];
   assign w_unused    = ^{bus.fu_op3, w_diff[32], w_fast_prod[65:64]};
`else
   assign w_unused    = ^{bus.fu_op3, w_diff[32]};
`endif

   // Control FSM and datapath registers; flush outranks start and grant
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_cnt          <= 5'd0;
         r_fin          <= 1'b0;
         r_spec         <= 1'b0;
         r_sel          <= 2'd0;
         r_acc          <= 66'd0;
         r_mcand        <= 66'd0;
         r_mplier       <= 33'd0;
         r_rem          <= 32'd0;
         r_quo          <= 32'd0;
         r_dvsr         <= 32'd0;
         r_neg_q        <= 1'b0;
         r_neg_r        <= 1'b0;
         r_cdb_req      <= 1'b0;
         r_res_value    <= '0;
         r_res_tag      <= '0;
         r_res_dest_reg <= 5'd0;
      end else if (bus.flush) begin
         r_state   <= S_IDLE;
         r_cdb_req <= 1'b0;
         r_cnt     <= 5'd0;
         r_fin     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.fu_start) begin
                  r_sel          <= w_f3[1:0];
                  r_res_tag      <= bus.fu_dest_tag;
                  r_res_dest_reg <= bus.fu_dest_reg;
                  r_cnt          <= 5'd0;
                  r_acc          <= w_acc_init;
                  r_mcand        <= w_a66;
                  r_mplier       <= w_b33;
                  r_rem          <= 32'd0;
                  r_quo          <= w_op1_mag;
                  r_dvsr         <= w_op2_mag;
                  r_neg_q        <= w_op1_neg ^ w_op2_neg;
                  r_neg_r        <= w_op1_neg;
                  // Resolved-at-issue cases still spend one cycle in a work state
                  r_fin          <= 1'b1;
                  r_spec         <= 1'b1;
                  r_state        <= S_DIV;
                  if (!w_legal) begin
                     r_res_value <= '0;
                  end else if (w_is_div) begin
                     if (w_div_zero) begin
                        r_res_value <= w_is_rem ? bus.fu_op1 : 32'hFFFF_FFFF;
                     end else if (w_div_ovf) begin
                        r_res_value <= w_is_rem ? 32'd0 : 32'h8000_0000;
                     end else begin
                        r_fin  <= 1'b0;
                        r_spec <= 1'b0;
                     end
                  end else begin
`ifdef MULDIV_FAST_MUL_EN
                     r_res_value <= w_fast_res;
                     r_state     <= S_MUL;
`else
                     r_fin       <= 1'b0;
                     r_spec      <= 1'b0;
                     r_state     <= S_MUL;
`endif
                  end
               end
            end
            S_MUL: begin
               if (r_fin) begin
                  if (!r_spec) r_res_value <= w_mul_res;
                  r_fin     <= 1'b0;
                  r_state   <= S_DONE;
                  r_cdb_req <= 1'b1;
               end else begin
                  r_acc    <= w_acc_step;
                  r_mcand  <= r_mcand << 1;
                  r_mplier <= r_mplier >> 1;
                  r_cnt    <= r_cnt + 5'd1;
                  if (r_cnt == 5'd31) r_fin <= 1'b1;
               end
            end
            S_DIV: begin
               if (r_fin) begin
                  if (!r_spec) r_res_value <= w_div_res;
                  r_fin     <= 1'b0;
                  r_state   <= S_DONE;
                  r_cdb_req <= 1'b1;
               end else begin
                  r_rem <= w_rem_ok ? w_diff[31:0] : w_rem_shift[31:0];
                  r_quo <= {r_quo[30:0], w_rem_ok};
                  r_cnt <= r_cnt + 5'd1;
                  if (r_cnt == 5'd31) r_fin <= 1'b1;
               end
            end
            S_DONE: begin
               if (bus.cdb_grant) begin
                  r_state   <= S_IDLE;
                  r_cdb_req <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.fu_ready     = (r_state == S_IDLE);
   assign bus.cdb_req      = r_cdb_req;
   assign bus.res_value    = r_res_value;
   assign bus.res_tag      = r_res_tag;
   assign bus.res_dest_reg = r_res_dest_reg;
endmodule
